// File: rtl/codebreaker_onchip_memory_arbiter.sv
// Weighted round-robin arbiter sharing one single-port 32-bit RAM between two Avalon-MM requesters.
// Optional contention counter enabled by defining CB_ARB_STATS_EN.
module codebreaker_onchip_memory_arbiter #(
    parameter int AW      = 14,
    parameter int WEIGHT0 = 1,
    parameter int WEIGHT1 = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          freeze,
    input  logic [AW-1:0] m0_address,
    input  logic [3:0]    m0_byteenable,
    input  logic          m0_read,
    input  logic          m0_write,
    input  logic [31:0]   m0_writedata,
    output logic          m0_waitrequest,
    output logic [31:0]   m0_readdata,
    output logic          m0_readdatavalid,
    input  logic [AW-1:0] m1_address,
    input  logic [3:0]    m1_byteenable,
    input  logic          m1_read,
    input  logic          m1_write,
    input  logic [31:0]   m1_writedata,
    output logic          m1_waitrequest,
    output logic [31:0]   m1_readdata,
    output logic          m1_readdatavalid,
    output logic [AW-1:0] mem_address,
    output logic [3:0]    mem_byteenable,
    output logic          mem_chipselect,
    output logic          mem_write,
    output logic [31:0]   mem_writedata,
    output logic          mem_clken,
    input  logic [31:0]   mem_readdata,
    output logic [15:0]   stat_conflicts
);

    typedef enum logic {OWN0, OWN1} owner_t;

    localparam logic [3:0] W0_L = 4'(WEIGHT0);
    localparam logic [3:0] W1_L = 4'(WEIGHT1);

    owner_t        owner_q, owner_d;
    logic [3:0]    credit_q, credit_d;
    logic          req0, req1, contended;
    logic          grant0, grant1, accept, acc_id;
    logic [AW-1:0] sel_addr, hold_addr;
    logic [3:0]    sel_be, hold_be;
    logic [31:0]   sel_wd, hold_wd;
    logic          sel_we;
    logic          pend_v_p1, pend_id_p1;
    logic          vld_p2, rid_p2;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign contended = req0 & req1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !freeze) begin
            if (req0 && (!req1 || owner_q == OWN0))
                grant0 = 1'b1;
            else if (req1)
                grant1 = 1'b1;
        end
    end

    assign accept         = grant0 | grant1;
    assign acc_id         = grant1;
    assign m0_waitrequest = req0 & ~grant0 & ~reset;
    assign m1_waitrequest = req1 & ~grant1 & ~reset;

    // Owner/credit: the owner keeps priority for WEIGHTowner consecutive contended grants.
    always_comb begin
        owner_d  = owner_q;
        credit_d = credit_q;
        if (accept) begin
            if (contended) begin
                if (credit_q + 4'd1 == ((owner_q == OWN0) ? W0_L : W1_L)) begin
                    owner_d  = (owner_q == OWN0) ? OWN1 : OWN0;
                    credit_d = 4'd0;
                end else begin
                    credit_d = credit_q + 4'd1;
                end
            end else if (acc_id == (owner_q == OWN1)) begin
                credit_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q  <= OWN0;
            credit_q <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            credit_q <= credit_d;
        end
    end

    // A write wins over a simultaneous read from the same port.
    always_comb begin
        sel_addr = hold_addr;
        sel_be   = hold_be;
        sel_wd   = hold_wd;
        sel_we   = 1'b0;
        if (grant0) begin
            sel_addr = m0_address;
            sel_be   = m0_write ? m0_byteenable : 4'hF;
            sel_wd   = m0_writedata;
            sel_we   = m0_write;
        end else if (grant1) begin
            sel_addr = m1_address;
            sel_be   = m1_write ? m1_byteenable : 4'hF;
            sel_wd   = m1_writedata;
            sel_we   = m1_write;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_addr <= sel_addr;
            hold_be   <= sel_be;
            hold_wd   <= sel_wd;
        end
    end

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_be;
    assign mem_writedata  = sel_wd;
    assign mem_write      = sel_we;
    assign mem_chipselect = accept;
    assign mem_clken      = ~reset;

    // Stage p1: read accepted last cycle, RAM q valid now. Stage p2: registered return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v_p1   <= 1'b0;
            pend_id_p1  <= 1'b0;
            vld_p2      <= 1'b0;
            rid_p2      <= 1'b0;
            m0_readdata <= 32'h0;
            m1_readdata <= 32'h0;
        end else begin
            pend_v_p1  <= accept & ~sel_we;
            pend_id_p1 <= acc_id;
            vld_p2     <= pend_v_p1;
            rid_p2     <= pend_id_p1;
            if (pend_v_p1 && !pend_id_p1)
                m0_readdata <= mem_readdata;
            if (pend_v_p1 && pend_id_p1)
                m1_readdata <= mem_readdata;
        end
    end

    assign m0_readdatavalid = vld_p2 & ~rid_p2;
    assign m1_readdatavalid = vld_p2 & rid_p2;

`ifdef CB_ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] conflicts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            conflicts_q <= 16'h0;
        else if (contended && !freeze)
            conflicts_q <= sat_inc16(conflicts_q);
    end

    assign stat_conflicts = conflicts_q;
`else
    assign stat_conflicts = 16'h0;
`endif

endmodule

// File: tb/tb_codebreaker_onchip_memory_arbiter.sv
// Bench for codebreaker_onchip_memory_arbiter: table vectors, directed corner sequences and
// randomized traffic checked against a transaction-level model (WEIGHT0=3 instance plus a 1/1 instance).
module tb_codebreaker_onchip_memory_arbiter;
    localparam int AW = 14;
    localparam int NWORDS = 1 << AW;

    logic clk = 1'b0, reset = 1'b1, freeze = 1'b0, ram_load = 1'b1;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0]   m0_writedata = '0, m1_writedata = '0;

    logic          a_wait0, a_wait1, a_rdv0, a_rdv1, a_cs, a_we, a_clken;
    logic [31:0]   a_rd0, a_rd1, a_wd, a_q;
    logic [AW-1:0] a_addr;
    logic [3:0]    a_be;
    logic [15:0]   a_stat;
    logic          b_wait0, b_wait1, b_rdv0, b_rdv1, b_cs, b_we, b_clken;
    logic [31:0]   b_rd0, b_rd1, b_wd, b_q;
    logic [AW-1:0] b_addr;
    logic [3:0]    b_be;
    logic [15:0]   b_stat;

    always #5 clk = ~clk;

    codebreaker_onchip_memory_arbiter #(.AW(AW), .WEIGHT0(3), .WEIGHT1(1)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(a_wait0),
        .m0_readdata(a_rd0), .m0_readdatavalid(a_rdv0),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(a_wait1),
        .m1_readdata(a_rd1), .m1_readdatavalid(a_rdv1),
        .mem_address(a_addr), .mem_byteenable(a_be), .mem_chipselect(a_cs), .mem_write(a_we),
        .mem_writedata(a_wd), .mem_clken(a_clken), .mem_readdata(a_q), .stat_conflicts(a_stat));

    codebreaker_onchip_memory_arbiter #(.AW(AW), .WEIGHT0(1), .WEIGHT1(1)) dut_b (
        .clk(clk), .reset(reset), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(b_wait0),
        .m0_readdata(b_rd0), .m0_readdatavalid(b_rdv0),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(b_wait1),
        .m1_readdata(b_rd1), .m1_readdatavalid(b_rdv1),
        .mem_address(b_addr), .mem_byteenable(b_be), .mem_chipselect(b_cs), .mem_write(b_we),
        .mem_writedata(b_wd), .mem_clken(b_clken), .mem_readdata(b_q), .stat_conflicts(b_stat));

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h0010) return 32'hCAFEF00D;
        if (i == 'h3FFF) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // RAM behind the WEIGHT0=3 instance; the 1/1 instance sees a RAM whose word equals B000_0000|address.
    logic [31:0] ram_a [0:NWORDS-1];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < NWORDS; i++) ram_a[i] <= init_word(i);
        end else if (a_clken && a_cs) begin
            if (a_we) begin
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) ram_a[a_addr][8*b +: 8] <= a_wd[8*b +: 8];
            end else begin
                a_q <= ram_a[a_addr];
            end
        end
    end
    always @(posedge clk) if (b_clken && b_cs && !b_we) b_q <= 32'hB000_0000 | 32'(b_addr);

    // Reference model state
    typedef struct { int due; bit id; logic [31:0] data; } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] ref_ram [0:NWORDS-1];
    int m_owner, m_credit, m_conf, cyc;
    int nvec = 0, nmis = 0;
    bit last_r0, last_r1, last_g0, last_g1, last_rst;
    logic obs_wait0, obs_wait1, obs_cs, obs_we, obs_rdv0, obs_rdv1;
    logic obs_bw0, obs_bw1, obs_brdv0, obs_brdv1;
    logic [31:0] obs_rd0, obs_brd0, obs_brd1;
    logic [15:0] obs_stat;

    function automatic int wgt(input int o);
        return (o == 0) ? 3 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock cycle: compare against the model at negedge, then advance the model.
    task automatic step();
        bit r0, r1, g0, g1, gid, rv0, rv1, we;
        logic [AW-1:0] addr;
        logic [3:0] be;
        logic [31:0] wd, exp_stat;
        @(negedge clk);
        if (reset) begin
            m_owner = 0; m_credit = 0; m_conf = 0;
            exp_q.delete();
        end
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        g0 = !reset && !freeze && r0 && (!r1 || m_owner == 0);
        g1 = !reset && !freeze && r1 && (!r0 || m_owner == 1);
        gid = g1;
        we   = gid ? m1_write : m0_write;
        addr = gid ? m1_address : m0_address;
        be   = gid ? m1_byteenable : m0_byteenable;
        wd   = gid ? m1_writedata : m0_writedata;
        chk("wait0", 32'(a_wait0), 32'(!reset && r0 && !g0));
        chk("wait1", 32'(a_wait1), 32'(!reset && r1 && !g1));
        chk("chipselect", 32'(a_cs), 32'(g0 || g1));
        chk("mem_write", 32'(a_we), 32'((g0 || g1) && we));
        chk("clken", 32'(a_clken), 32'(!reset));
        if (g0 || g1) begin
            chk("mem_address", 32'(a_addr), 32'(addr));
            chk("mem_byteenable", 32'(a_be), we ? 32'(be) : 32'hF);
            if (we) chk("mem_writedata", a_wd, wd);
        end
        rv0 = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].id == 1'b0;
        rv1 = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].id == 1'b1;
        chk("rdvalid0", 32'(a_rdv0), 32'(rv0));
        chk("rdvalid1", 32'(a_rdv1), 32'(rv1));
        if (rv0) chk("readdata0", a_rd0, exp_q[0].data);
        if (rv1) chk("readdata1", a_rd1, exp_q[0].data);
        if (rv0 || rv1) void'(exp_q.pop_front());
        if (reset) begin
            chk("readdata0_rst", a_rd0, 32'h0);
            chk("readdata1_rst", a_rd1, 32'h0);
        end
`ifdef CB_ARB_STATS_EN
        exp_stat = 32'(m_conf);
`else
        exp_stat = 32'h0;
`endif
        chk("stat_conflicts", 32'(a_stat), exp_stat);
        obs_wait0 = a_wait0; obs_wait1 = a_wait1; obs_cs = a_cs; obs_we = a_we;
        obs_rdv0 = a_rdv0; obs_rdv1 = a_rdv1; obs_rd0 = a_rd0; obs_stat = a_stat;
        obs_bw0 = b_wait0; obs_bw1 = b_wait1; obs_brdv0 = b_rdv0; obs_brdv1 = b_rdv1;
        obs_brd0 = b_rd0; obs_brd1 = b_rd1;
        if (!reset) begin
            if (g0 || g1) begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_ram[addr][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    exp_q.push_back('{cyc + 2, gid, ref_ram[addr]});
                end
                if (r0 && r1) begin
                    m_credit++;
                    if (m_credit == wgt(m_owner)) begin
                        m_owner = 1 - m_owner;
                        m_credit = 0;
                    end
                end else if (int'(gid) == m_owner) begin
                    m_credit = 0;
                end
            end
            if (r0 && r1 && !freeze && m_conf < 65535) m_conf++;
        end
        last_r0 = r0; last_r1 = r1; last_g0 = g0; last_g1 = g1; last_rst = reset;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_req(input bit r0, input bit w0, input bit r1, input bit w1);
        m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1;
    endtask

    typedef struct { bit r0, w0, r1, w1, fr, e_w0, e_w1, e_cs, e_we; } vec_t;
    vec_t tbl[12];

    initial begin
        int cnt, k;
        tbl[0]  = '{1,0,0,0,0, 0,0,1,0};
        tbl[1]  = '{0,0,1,0,0, 0,0,1,0};
        tbl[2]  = '{1,0,1,0,0, 0,1,1,0};
        tbl[3]  = '{1,0,1,0,0, 0,1,1,0};
        tbl[4]  = '{1,0,1,0,1, 1,1,0,0};
        tbl[5]  = '{1,0,1,0,0, 0,1,1,0};
        tbl[6]  = '{1,0,1,0,0, 1,0,1,0};
        tbl[7]  = '{1,1,0,0,0, 0,0,1,1};
        tbl[8]  = '{0,0,0,0,0, 0,0,0,0};
        tbl[9]  = '{1,0,0,1,0, 0,1,1,0};
        tbl[10] = '{0,0,0,1,0, 0,0,1,1};
        tbl[11] = '{0,0,0,0,0, 0,0,0,0};
        for (int i = 0; i < NWORDS; i++) ref_ram[i] = init_word(i);
        cyc = 0; m_owner = 0; m_credit = 0; m_conf = 0;
        #1;

        // Reset, RAM load
        for (int i = 0; i < 3; i++) step();
        ram_load = 1'b0;
        reset = 1'b0;

        // Lone m0 read of 0x0010
        m0_address = 14'h0010; set_req(1, 0, 0, 0);
        step();
        chk("t1_wait0", 32'(obs_wait0), 32'h0);
        set_req(0, 0, 0, 0);
        step(); step();
        chk("t1_rdvalid", 32'(obs_rdv0), 32'h1);
        chk("t1_readdata", obs_rd0, 32'hCAFEF00D);

        // Vector table from owner=0, credit=0
        for (int i = 0; i < 12; i++) begin
            set_req(tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1);
            freeze = tbl[i].fr;
            m0_address = 14'(16'h0100 + i); m1_address = 14'(16'h0200 + i);
            m0_byteenable = 4'(i); m1_byteenable = 4'hF - 4'(i);
            m0_writedata = 32'h1111_0000 + 32'(i); m1_writedata = 32'h2222_0000 + 32'(i);
            step();
            chk($sformatf("vec%0d_wait0", i), 32'(obs_wait0), 32'(tbl[i].e_w0));
            chk($sformatf("vec%0d_wait1", i), 32'(obs_wait1), 32'(tbl[i].e_w1));
            chk($sformatf("vec%0d_cs", i), 32'(obs_cs), 32'(tbl[i].e_cs));
            chk($sformatf("vec%0d_we", i), 32'(obs_we), 32'(tbl[i].e_we));
        end
        freeze = 1'b0;

        // Continuous contention: 3:1 pattern on dut, strict alternation on dut_b
        reset = 1'b1; step(); step(); reset = 1'b0;
        m0_address = 14'h0020; m1_address = 14'h0021; set_req(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("w3_wait0", 32'(obs_wait0), 32'(i % 4 == 3));
            chk("w3_wait1", 32'(obs_wait1), 32'(i % 4 != 3));
            chk("w1_wait0", 32'(obs_bw0), 32'(i % 2 == 1));
            chk("w1_wait1", 32'(obs_bw1), 32'(i % 2 == 0));
            if (i >= 2) begin
                chk("w1_rdvalid0", 32'(obs_brdv0), 32'(i % 2 == 0));
                chk("w1_rdvalid1", 32'(obs_brdv1), 32'(i % 2 == 1));
                if (i % 2 == 0) chk("w1_readdata0", obs_brd0, 32'hB000_0020);
                else            chk("w1_readdata1", obs_brd1, 32'hB000_0021);
            end
        end
        set_req(0, 0, 0, 0);
        step();
`ifdef CB_ARB_STATS_EN
        chk("conflicts_8", 32'(obs_stat), 32'd8);
`else
        chk("conflicts_off", 32'(obs_stat), 32'd0);
`endif
        step(); step();

        // Partial write then read of the same word on the next cycle
        m1_address = 14'h3FFF; m1_byteenable = 4'b0011; m1_writedata = 32'h12345678;
        set_req(0, 0, 0, 1);
        step();
        m0_address = 14'h3FFF; set_req(1, 0, 0, 0);
        step();
        set_req(0, 0, 0, 0);
        step(); step();
        chk("wr_rd_valid", 32'(obs_rdv0), 32'h1);
        chk("wr_rd_data", obs_rd0, 32'hDEAD5678);

        // Freeze with a read in flight
        m0_address = 14'h0030; m1_address = 14'h0031; set_req(1, 0, 1, 0);
        step();
        freeze = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("frz_wait0", 32'(obs_wait0), 32'h1);
            chk("frz_wait1", 32'(obs_wait1), 32'h1);
            cnt += int'(obs_rdv0) + int'(obs_rdv1);
        end
        chk("frz_inflight", 32'(cnt), 32'd1);
        freeze = 1'b0;
        step();
        chk("frz_resume", 32'(obs_cs), 32'h1);
        set_req(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();

        // Reset the cycle after a read accept
        m0_address = 14'h0040; set_req(1, 0, 0, 0);
        step();
        reset = 1'b1;
        step();
        chk("rst_wait0", 32'(obs_wait0), 32'h0);
        chk("rst_cs", 32'(obs_cs), 32'h0);
        step();
        reset = 1'b0; set_req(0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt += int'(obs_rdv0) + int'(obs_rdv1);
        end
        chk("rst_discard", 32'(cnt), 32'd0);

        // Randomized traffic; a refused request is held until accepted
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 499) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            if (!(last_r0 && !last_g0) || last_rst) begin
                k = int'($urandom_range(0, 3));
                m0_read = (k == 1 || k == 3); m0_write = (k >= 2);
                m0_address = 14'($urandom_range(0, 31));
                m0_byteenable = 4'($urandom_range(0, 15));
                m0_writedata = $urandom;
            end
            if (!(last_r1 && !last_g1) || last_rst) begin
                k = int'($urandom_range(0, 3));
                m1_read = (k == 1 || k == 3); m1_write = (k >= 2);
                m1_address = 14'($urandom_range(0, 31));
                m1_byteenable = 4'($urandom_range(0, 15));
                m1_writedata = $urandom;
            end
            step();
        end
        reset = 1'b0; freeze = 1'b0; set_req(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
